// File: rtl/conv_pkg.sv
// Shared definitions for the converter: top-level op codes and the
// conversion-engine state encodings.
package conv_pkg;

    localparam logic [2:0] OP_BIN2GRAY = 3'd0;
    localparam logic [2:0] OP_GRAY2BIN = 3'd1;
    localparam logic [2:0] OP_BIN2BCD  = 3'd2;
    localparam logic [2:0] OP_BCD2BIN  = 3'd3;
    localparam logic [2:0] OP_BIN2EX3  = 3'd4;
    localparam logic [2:0] OP_EX32BCD  = 3'd5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } eng_state_e;

    // Double-dabble digit correction: a digit of 5 or more would carry
    // past 9 after doubling, so pre-bias it by 3.
    function automatic logic [3:0] digit_add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_engine_if.sv
// Engine start/done handshake bundle. The ovf signal exists only when
// BIN2BCD_OVF_EN is defined.
interface bin2bcd_engine_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_OVF_EN
    logic                  ovf;

    modport master (output start, bin_in, input busy, done, bcd_out, ovf);
    modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
`else
    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif
endinterface

// File: rtl/bcd_add3.sv
// Single-digit combinational add-3 corrector used by the double-dabble
// shift stage.
module bcd_add3
    import conv_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Correct one digit ahead of the shift
    always_comb begin
        o_digit = digit_add3(i_digit);
    end

endmodule

// File: rtl/bin2bcd_engine.sv
// Sequential shift-and-add-3 binary-to-BCD engine, one bit per cycle.
// Optional overflow flag enabled by defining BIN2BCD_OVF_EN.
module bin2bcd_engine
    import conv_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    bin2bcd_engine_if.slave   eng
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    eng_state_e         r_state;
    eng_state_e         w_state_nxt;
    logic               w_load;
    logic               w_shift_en;
    logic               w_last;
    logic               r_busy;
    logic               r_done;

    logic [BIN_W-1:0]   r_shift;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_adj;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_bcd;

    // State register plus Moore outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (eng.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_shift_en = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .i_digit (r_acc[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // The top corrected bit falls off the accumulator; only the ovf tracker sees it.
    assign w_acc_nxt = {w_adj[ACC_W-2:0], r_shift[BIN_W-1]};

    // Shift register, accumulator, bit counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= {BIN_W{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_bcd   <= {ACC_W{1'b0}};
        end else if (w_load) begin
            r_shift <= eng.bin_in;
            r_acc   <= {ACC_W{1'b0}};
            r_cnt   <= CNT_W'(BIN_W);
        end else if (w_shift_en) begin
            r_shift <= {r_shift[BIN_W-2:0], 1'b0};
            r_acc   <= w_acc_nxt;
            r_cnt   <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_bcd <= w_acc_nxt;
            end
        end
    end

`ifdef BIN2BCD_OVF_EN
    logic r_ovf_trk;
    logic r_ovf;

    // Sticky record of any set bit lost off the top digit, published with the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_trk <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_load) begin
            r_ovf_trk <= 1'b0;
        end else if (w_shift_en) begin
            r_ovf_trk <= r_ovf_trk | w_adj[ACC_W-1];
            if (w_last) begin
                r_ovf <= r_ovf_trk | w_adj[ACC_W-1];
            end
        end
    end

    assign eng.ovf = r_ovf;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_adj[ACC_W-1];
`endif

    assign eng.busy    = r_busy;
    assign eng.done    = r_done;
    assign eng.bcd_out = r_bcd;

endmodule
